// File: rtl/result_collector_pkg.sv
// Shared constants for the 2x2 matrix-multiply datapath (input sequencer and result collector).
package result_collector_pkg;

    localparam int unsigned N_ELEM = 4;
    localparam int unsigned DW_DEF = 16;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/result_collector.sv
// Collects the serial c00,c01,c10,c11 result stream into a parallel 2x2 frame.
// The completed frame is held with backpressure until the consumer takes it.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] c0,
    output logic [DW-1:0] c1,
    output logic [DW-1:0] c2,
    output logic [DW-1:0] c3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          frame_err
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                err_q, err_d;
    logic [DW-1:0]       c_q [N_ELEM];
    logic [N_ELEM-1:0]   wr_en_c;
    logic                accept_c;

    // State, index and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: frame start, element sequencing, resync and release.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (in_first) begin
                        idx_d   = IDX_W'(1);
                        state_d = ST_COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (accept_c) begin
                    if (in_first) begin
                        err_d = 1'b1;
                        idx_d = IDX_W'(1);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(N_ELEM - 1)) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: handshake flags and element write enables.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        wr_en_c   = '0;
        case (state_q)
            ST_IDLE:    in_ready  = 1'b1;
            ST_COLLECT: in_ready  = 1'b1;
            ST_HOLD:    out_valid = 1'b1;
            default:    in_ready  = 1'b0;
        endcase
        accept_c = in_valid && in_ready;
        if (accept_c) begin
            if (in_first) begin
                wr_en_c[0] = 1'b1;
            end else if (state_q == ST_COLLECT) begin
                wr_en_c[idx_q] = 1'b1;
            end
        end
    end

    // Result element registers; only the addressed element changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(N_ELEM); i++) begin
                c_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_ELEM); i++) begin
                if (wr_en_c[i]) begin
                    c_q[i] <= in_data;
                end
            end
        end
    end

    assign c0        = c_q[0];
    assign c1        = c_q[1];
    assign c2        = c_q[2];
    assign c3        = c_q[3];
    assign frame_err = err_q;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed scenarios plus random traffic against a frame-level model.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_first;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] c0, c1, c2, c3;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: partial frame as a queue, visible matrix, held flag, sticky error.
    logic [15:0] m_part [$];
    logic [15:0] m_disp [4];
    bit          m_hold;
    bit          m_err;

    result_collector #(.DW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_part.delete();
        for (int i = 0; i < 4; i++) m_disp[i] = '0;
        m_hold = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock of the model, using the inputs present at the coming edge.
    task automatic model_step(input bit rst, input bit v, input bit f,
                              input logic [15:0] d, input bit ordy);
        if (rst) begin
            model_reset();
        end else if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (v) begin
            if (f) begin
                if (m_part.size() != 0) m_err = 1'b1;
                m_part.delete();
                m_part.push_back(d);
                m_disp[0] = d;
            end else if (m_part.size() == 0) begin
                m_err = 1'b1;
            end else begin
                m_disp[m_part.size()] = d;
                m_part.push_back(d);
                if (m_part.size() == 4) begin
                    m_hold = 1'b1;
                    m_part.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        check("in_ready",  32'(in_ready),  32'(!m_hold));
        check("out_valid", 32'(out_valid), 32'(m_hold));
        check("frame_err", 32'(frame_err), 32'(m_err));
        check("c0", 32'(c0), 32'(m_disp[0]));
        check("c1", 32'(c1), 32'(m_disp[1]));
        check("c2", 32'(c2), 32'(m_disp[2]));
        check("c3", 32'(c3), 32'(m_disp[3]));
    endtask

    task automatic step(input bit rst, input bit v, input bit f,
                        input logic [15:0] d, input bit ordy);
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_first  = f;
        in_data   = d;
        out_ready = ordy;
        model_step(rst, v, f, d, ordy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, ordy);
    endtask

    task automatic frame(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] e, input int gap);
        step(1'b0, 1'b1, 1'b1, a, 1'b0); idle(gap, 1'b0);
        step(1'b0, 1'b1, 1'b0, b, 1'b0); idle(gap, 1'b0);
        step(1'b0, 1'b1, 1'b0, c, 1'b0); idle(gap, 1'b0);
        step(1'b0, 1'b1, 1'b0, e, 1'b0);
    endtask

    task automatic release_frame();
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);

        // Nominal frame, consecutive beats.
        frame(16'd13, 16'd16, 16'd29, 16'd36, 0);
        check("nom_valid", 32'(out_valid), 32'd1);
        check("nom_c0", 32'(c0), 32'd13);
        check("nom_c3", 32'(c3), 32'd36);
        check("nom_err", 32'(frame_err), 32'd0);

        // Backpressure with input pressure in HOLD.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 16'd99, 1'b0);
        check("bp_c1", 32'(c1), 32'd16);
        release_frame();
        check("rel_valid", 32'(out_valid), 32'd0);
        check("rel_ready", 32'(in_ready), 32'd1);

        // Gapped input.
        frame(16'd13, 16'd16, 16'd29, 16'd36, 2);
        check("gap_c2", 32'(c2), 32'd29);
        release_frame();

        // Missing start while idle.
        step(1'b0, 1'b1, 1'b0, 16'd7, 1'b0);
        check("miss_err", 32'(frame_err), 32'd1);
        frame(16'd1, 16'd2, 16'd3, 16'd4, 0);
        check("miss_c0", 32'(c0), 32'd1);
        release_frame();

        // Resync mid-frame after a fresh reset.
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'd5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'd6, 1'b0);
        frame(16'd13, 16'd16, 16'd29, 16'd36, 0);
        check("resync_err", 32'(frame_err), 32'd1);
        check("resync_c1", 32'(c1), 32'd16);
        release_frame();

        // Reset mid-frame.
        step(1'b0, 1'b1, 1'b1, 16'd21, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'd22, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        check("mid_rst_c0", 32'(c0), 32'd0);
        frame(16'd13, 16'd16, 16'd29, 16'd36, 0);
        check("post_rst_c3", 32'(c3), 32'd36);
        release_frame();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit v, f, r, o;
            logic [15:0] d;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 9) < 7);
            if (m_part.size() == 0) f = ($urandom_range(0, 9) < 8);
            else                    f = ($urandom_range(0, 19) == 0);
            o = $urandom_range(0, 1) == 1;
            d = 16'($urandom);
            step(r, v, f, d, o);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
